// File: rtl/hazard_unit.sv
// hazard_unit -- forwarding, load-use stall and branch flush control for a
// classic five-stage pipeline.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   rs_addrD, rt_addrD  source registers of the Decode instruction
//   uses_rsD, uses_rtD  Decode instruction really reads rs / rt
//   write_reg_addrE     destination of the Execute instruction
//   reg_writeE          Execute instruction writes a register
//   mem_to_regE         Execute instruction is a load
//   branch_takenM       branch in Memory resolved taken
//   fw_alu1, fw_alu2    registered forwarding selects for the instruction in
//                       Execute (10 = alu_outM, 01 = write_resultW, 00 = RF)
//   stallF, stallD      hold PC / IF-ID register
//   flushD, flushE      bubble IF-ID / ID-EX register
//   stall_cycles        saturating count of load-use stall cycles
module hazard_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs_addrD,
  input  logic [4:0]       rt_addrD,
  input  logic             uses_rsD,
  input  logic             uses_rtD,
  input  logic [4:0]       write_reg_addrE,
  input  logic             reg_writeE,
  input  logic             mem_to_regE,
  input  logic             branch_takenM,
  output logic [1:0]       fw_alu1,
  output logic [1:0]       fw_alu2,
  output logic             stallF,
  output logic             stallD,
  output logic             flushD,
  output logic             flushE,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    FW_RF  = 2'b00,
    FW_WB  = 2'b01,
    FW_MEM = 2'b10
  } fw_sel_e;

  // Stage trackers packed as {addr[4:0], wr}.
  logic [5:0]       trkM_q, trkM_d;
  logic [5:0]       trkW_q, trkW_d;
  fw_sel_e          fw1_q, fw1_d;
  fw_sel_e          fw2_q, fw2_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic [4:0] addrM;
  logic       wrM;
  logic       matchE_rs, matchE_rt, matchM_rs, matchM_rt;
  logic       load_use;

  assign addrM = trkM_q[5:1];
  assign wrM   = trkM_q[0];

  always_comb begin
    matchE_rs = uses_rsD & reg_writeE & (write_reg_addrE != '0) & (write_reg_addrE == rs_addrD);
    matchE_rt = uses_rtD & reg_writeE & (write_reg_addrE != '0) & (write_reg_addrE == rt_addrD);
    matchM_rs = uses_rsD & wrM & (addrM != '0) & (addrM == rs_addrD);
    matchM_rt = uses_rtD & wrM & (addrM != '0) & (addrM == rt_addrD);
    load_use  = mem_to_regE & (matchE_rs | matchE_rt);
  end

  // Pipeline control; a taken branch wins over a simultaneous load-use.
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    if (!reset) begin
      if (branch_takenM) begin
        flushD = 1'b1;
        flushE = 1'b1;
      end else if (load_use) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
    end
  end

  // Next-state: trackers, forwarding selects, stall counter.
  // The W tracker is kept for observability only; the register file is
  // write-before-read so it never feeds a forwarding select.
  always_comb begin
    trkW_d         = trkM_q;
    trkM_d         = branch_takenM ? '0 : {write_reg_addrE, reg_writeE};
    fw1_d          = FW_RF;
    fw2_d          = FW_RF;
    stall_cycles_d = stall_cycles_q;

    if (!branch_takenM && !load_use) begin
      if (matchE_rs)      fw1_d = FW_MEM;
      else if (matchM_rs) fw1_d = FW_WB;
      if (matchE_rt)      fw2_d = FW_MEM;
      else if (matchM_rt) fw2_d = FW_WB;
    end

    if (load_use && !branch_takenM && (stall_cycles_q != '1))
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trkM_q         <= '0;
      trkW_q         <= '0;
      fw1_q          <= FW_RF;
      fw2_q          <= FW_RF;
      stall_cycles_q <= '0;
    end else begin
      trkM_q         <= trkM_d;
      trkW_q         <= trkW_d;
      fw1_q          <= fw1_d;
      fw2_q          <= fw2_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // Trackers must read as empty whenever reset is held across an edge.
  a_reset_clears_trackers: assert property (@(posedge clk) reset |-> ((trkM_q == '0) && (trkW_q == '0)));

  assign fw_alu1      = fw1_q;
  assign fw_alu2      = fw2_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_addrD, rt_addrD, write_reg_addrE;
  logic       uses_rsD, uses_rtD, reg_writeE, mem_to_regE, branch_takenM;
  logic [1:0] fw_alu1, fw_alu2;
  logic       stallF, stallD, flushD, flushE;
  logic [3:0] stall_cycles;

  int unsigned errors = 0;
  int unsigned checks = 0;

  hazard_unit #(.CNT_W(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .rs_addrD        (rs_addrD),
    .rt_addrD        (rt_addrD),
    .uses_rsD        (uses_rsD),
    .uses_rtD        (uses_rtD),
    .write_reg_addrE (write_reg_addrE),
    .reg_writeE      (reg_writeE),
    .mem_to_regE     (mem_to_regE),
    .branch_takenM   (branch_takenM),
    .fw_alu1         (fw_alu1),
    .fw_alu2         (fw_alu2),
    .stallF          (stallF),
    .stallD          (stallD),
    .flushD          (flushD),
    .flushE          (flushE),
    .stall_cycles    (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_d(input logic [4:0] rs, input logic urs, input logic [4:0] rt, input logic urt);
    rs_addrD = rs; uses_rsD = urs; rt_addrD = rt; uses_rtD = urt;
  endtask

  task automatic set_e(input logic [4:0] addr, input logic wr, input logic ld);
    write_reg_addrE = addr; reg_writeE = wr; mem_to_regE = ld;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Combinational control snapshot {stallF, stallD, flushD, flushE}.
  function automatic logic [7:0] ctl();
    return {4'b0, stallF, stallD, flushD, flushE};
  endfunction

  initial begin
    reset = 1'b1;
    branch_takenM = 1'b1;
    set_d(5'd0, 1'b0, 5'd0, 1'b0);
    set_e(5'd0, 1'b0, 1'b0);
    #12;
    // Reset state; branch held high must not flush during reset.
    check("rst_fw1", {6'b0, fw_alu1}, 8'h0);
    check("rst_fw2", {6'b0, fw_alu2}, 8'h0);
    check("rst_ctl", ctl(), 8'h0);
    check("rst_cnt", {4'b0, stall_cycles}, 8'h0);
    reset = 1'b0;
    branch_takenM = 1'b0;
    tick;

    // ALU result in E forwards from M next cycle.
    set_e(5'd8, 1'b1, 1'b0);
    set_d(5'd8, 1'b1, 5'd3, 1'b1);
    #1 check("alu_ctl", ctl(), 8'h0);
    tick;
    check("alu_fw1", {6'b0, fw_alu1}, 8'h2);
    check("alu_fw2", {6'b0, fw_alu2}, 8'h0);
    // Same producer now in M tracker -> select write_result.
    set_e(5'd0, 1'b0, 1'b0);
    tick;
    check("m_fw1", {6'b0, fw_alu1}, 8'h1);
    // Producer only in W: no forwarding.
    tick;
    check("w_nofw", {6'b0, fw_alu1}, 8'h0);

    // Load-use on rt.
    set_e(5'd9, 1'b1, 1'b1);
    set_d(5'd2, 1'b1, 5'd9, 1'b1);
    #1 check("lu_ctl", ctl(), 8'b1101);
    check("lu_cnt0", {4'b0, stall_cycles}, 8'h0);
    tick;
    check("lu_cnt1", {4'b0, stall_cycles}, 8'h1);
    check("lu_fw2z", {6'b0, fw_alu2}, 8'h0);
    set_e(5'd0, 1'b0, 1'b0);
    #1 check("lu_nostall", ctl(), 8'h0);
    tick;
    check("lu_fw2", {6'b0, fw_alu2}, 8'h1);
    check("lu_fw1", {6'b0, fw_alu1}, 8'h0);

    // E and M both write $5: E has priority.
    set_d(5'd0, 1'b0, 5'd0, 1'b0);
    set_e(5'd5, 1'b1, 1'b0);
    tick;
    set_d(5'd5, 1'b1, 5'd5, 1'b1);
    #1 check("pri_ctl", ctl(), 8'h0);
    tick;
    check("pri_fw1", {6'b0, fw_alu1}, 8'h2);
    check("pri_fw2", {6'b0, fw_alu2}, 8'h2);

    // Load to $0 never stalls or forwards.
    set_e(5'd0, 1'b1, 1'b1);
    set_d(5'd0, 1'b1, 5'd0, 1'b1);
    #1 check("r0_ctl", ctl(), 8'h0);
    tick;
    check("r0_fw1", {6'b0, fw_alu1}, 8'h0);
    check("r0_fw2", {6'b0, fw_alu2}, 8'h0);
    check("r0_cnt", {4'b0, stall_cycles}, 8'h1);

    // Load-use together with a taken branch: branch wins.
    set_e(5'd7, 1'b1, 1'b1);
    set_d(5'd7, 1'b1, 5'd0, 1'b0);
    branch_takenM = 1'b1;
    #1 check("br_ctl", ctl(), 8'b0011);
    tick;
    check("br_cnt", {4'b0, stall_cycles}, 8'h1);
    check("br_fw1", {6'b0, fw_alu1}, 8'h0);
    branch_takenM = 1'b0;
    set_e(5'd0, 1'b0, 1'b0);
    tick;
    check("br_mtrk", {6'b0, fw_alu1}, 8'h0);

    // Saturation: 20 more load-use stalls from count 1.
    set_e(5'd9, 1'b1, 1'b1);
    set_d(5'd0, 1'b0, 5'd9, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (i == 13) check("sat_pre", {4'b0, stall_cycles}, 8'he);
      tick;
    end
    check("sat_cnt", {4'b0, stall_cycles}, 8'hf);
    #1 check("sat_ctl", ctl(), 8'b1101);

    // Asynchronous reset mid-stall.
    reset = 1'b1;
    #1;
    check("arst_cnt", {4'b0, stall_cycles}, 8'h0);
    check("arst_ctl", ctl(), 8'h0);
    #1 reset = 1'b0;
    set_e(5'd0, 1'b0, 1'b0);
    tick;
    check("arst_mtrk", {6'b0, fw_alu2}, 8'h0);
    check("arst_cnt2", {4'b0, stall_cycles}, 8'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the stall-cycle counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports rs_addrD / rt_addrD  input  5 each  source register numbers of the instruction in Decode.
REQ-005 SHALL have ports uses_rsD / uses_rtD  input  1 each  Decode instruction actually reads rs / rt.
REQ-006 SHALL have port write_reg_addrE  input  5  destination of the instruction in Execute.
REQ-007 SHALL have ports reg_writeE / mem_to_regE  input  1 each  Execute instruction writes a register / is a load.
REQ-008 SHALL have port branch_takenM  input  1  branch in Memory stage resolved taken.
REQ-009 SHALL have ports fw_alu1 / fw_alu2  output  2 each  registered forwarding selects for the Execute instruction: 10 = alu_outM, 01 = write_resultW, 00 = register file.
REQ-010 SHALL have ports stallF / stallD  output  1 each  hold the PC / the IF-ID register.
REQ-011 SHALL have ports flushD / flushE  output  1 each  bubble the IF-ID / ID-EX register.
REQ-012 SHALL have port stall_cycles  output  CNT_W  count of load-use stall cycles.

Function
REQ-013 SHALL keep internal Memory-stage tracker (addrM 5b, wrM) and Writeback-stage tracker (addrW 5b, wrW).
REQ-014 SHALL, every edge: W tracker <= M tracker; M tracker <= {write_reg_addrE, reg_writeE}, or {0,0} when branch_takenM = 1.
REQ-015 SHALL define matchE(src) = uses & reg_writeE & write_reg_addrE != 0 & write_reg_addrE == src; matchM(src) likewise using wrM, addrM.
REQ-016 SHALL compute next fw_alu1 for rs_addrD / uses_rsD: 10 if matchE, else 01 if matchM, else 00; fw_alu2 identically for rt; matchE has priority.
REQ-017 SHALL register next fw values into fw_alu1 / fw_alu2 each edge, giving 1-cycle latency aligned to the Decode instruction entering Execute.
REQ-018 SHALL NOT forward from the current Writeback instruction; the register file is write-before-read.
REQ-019 SHALL detect load-use = mem_to_regE & (matchE(rs) | matchE(rt)), combinationally.
REQ-020 SHALL on load-use (branch_takenM = 0): stallF = stallD = 1, flushE = 1, flushD = 0; fw registers load 00 at that edge.
REQ-021 SHALL, in the cycle after a load-use stall, resolve the load via the M tracker so the dependent instruction receives fw = 01.
REQ-022 SHALL on branch_takenM = 1: flushD = flushE = 1, stallF = stallD = 0; fw registers load 00; branch overrides load-use in the same cycle.
REQ-023 SHALL treat register 0 as never matching; a write to $0 never forwards or stalls.
REQ-024 SHALL increment stall_cycles by 1 on each edge where load-use is asserted and branch_takenM = 0, saturating at all-ones.
REQ-025 SHALL generate stallF, stallD, flushD, flushE combinationally from current inputs and tracker state.

Reset
REQ-026 SHALL on reset assertion immediately clear fw_alu1 / fw_alu2 to 00, both trackers to {0,0}, and stall_cycles to 0.
REQ-027 SHALL force stallF, stallD, flushD, flushE to 0 while reset is high.
REQ-028 SHALL resume normal tracking on the first rising edge after reset deasserts; a mid-stall reset discards the pending stall.

Verification
REQ-029 SHALL pass: E writes $8 (ALU), D reads rs = $8 -> next cycle fw_alu1 = 10, fw_alu2 = 00, no stall.
REQ-030 SHALL pass: E = lw $9, D reads rt = $9 -> stallF = stallD = flushE = 1 that cycle, stall_cycles 0 -> 1; next cycle no stall; following cycle fw_alu2 = 01.
REQ-031 SHALL pass: E and M trackers both write $5, D reads rs = rt = $5 -> fw_alu1 = fw_alu2 = 10.
REQ-032 SHALL pass: E = lw $0, D reads $0 -> no stall, fw = 00.
REQ-033 SHALL pass: load-use and branch_takenM together -> flushD = flushE = 1, stallF = 0, stall_cycles unchanged, following-cycle M tracker wr = 0.
REQ-034 SHALL pass: force stall_cycles to all-ones via repeated load-use (CNT_W = 4, 20 stalls) -> holds 4'hF; reset pulse -> 0 asynchronously.
